mem_arb: RTL and testbench

Two-port arbiter that shares the computer's single synchronous-read memory between the CPU bus (port 0) and a debug/loader port (port 1) driven by the monitor logic. It sits between the requesters and the memory inside `comp`. It serialises single-beat read/write transactions with round-robin fairness, optional bounded bus locking and a fixed three-cycle access sequence.

---
 rtl/p12_pkg.sv | 15 +
 rtl/mem_arb_if.sv | 50 +++++
 rtl/mem_arb_rr_pick2.sv | 23 ++
 rtl/mem_arb.sv | 131 +++++++++++++
 tb/tb_mem_arb.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p12_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding and port indices.
package p12_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of both requester ports, the memory bus and arbiter status.
// slave = arbiter side, master = requesters plus memory.
interface mem_arb_if #(
    parameter int WIDTH         = 32,
    parameter int MEM_ADDR_SIZE = 12
);
    logic                     r0_req;
    logic                     r0_wen;
    logic                     r0_lock;
    logic [MEM_ADDR_SIZE-1:0] r0_addr;
    logic [WIDTH-1:0]         r0_wdata;
    logic                     r0_ack;
    logic [WIDTH-1:0]         r0_rdata;

    logic                     r1_req;
    logic                     r1_wen;
    logic                     r1_lock;
    logic [MEM_ADDR_SIZE-1:0] r1_addr;
    logic [WIDTH-1:0]         r1_wdata;
    logic                     r1_ack;
    logic [WIDTH-1:0]         r1_rdata;

    logic                     mem_cs;
    logic                     mem_wen;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;

    logic                     owner;
    logic                     busy;

    modport slave (
        input  r0_req, r0_wen, r0_lock, r0_addr, r0_wdata,
        input  r1_req, r1_wen, r1_lock, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_ack, r0_rdata, r1_ack, r1_rdata,
        output mem_cs, mem_wen, mem_addr, mem_wdata,
        output owner, busy
    );

    modport master (
        output r0_req, r0_wen, r0_lock, r0_addr, r0_wdata,
        output r1_req, r1_wen, r1_lock, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_ack, r0_rdata, r1_ack, r1_rdata,
        input  mem_cs, mem_wen, mem_addr, mem_wdata,
        input  owner, busy
    );

endinterface

// File: rtl/mem_arb_rr_pick2.sv
// Combinational two-way grant picker: round-robin on ties, with a bounded lock
// that lets the last owner win while its lock is valid and the counter is not full.
module rr_pick2
    import p12_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_full,
    output logic       grant
);

    always_comb begin
        grant = PORT_CPU;
        case (reqs)
            2'b01:   grant = PORT_CPU;
            2'b10:   grant = PORT_DBG;
            2'b11:   grant = (lock_valid && !lock_full) ? last : other_port(last);
            default: grant = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter for the shared synchronous-read memory (CPU on port 0, debug on port 1).
// state | meaning
// IDLE  | sample requests, grant one and latch its fields
// ISSUE | mem_cs high for one cycle with the owner's fields
// RESP  | owner's ack pulse, rdata passed through from memory on reads
module mem_arb
    import p12_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MEM_ADDR_SIZE = 12,
    parameter int LOCK_MAX      = 8
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb_if.slave  bus
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [1:0]               state;
    logic                     busy_q;
    logic                     cs_q;
    logic                     wen_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [WIDTH-1:0]         wdata_q;
    logic                     owner_q;
    logic                     ack0_q;
    logic                     ack1_q;
    logic                     last;
    logic                     lock_valid;
    logic [CW-1:0]            lock_cnt;

    logic [1:0]               reqs;
    logic                     grant;
    logic                     lock_full;
    logic                     other_req;
    logic                     sel_wen;
    logic                     sel_lock;
    logic [MEM_ADDR_SIZE-1:0] sel_addr;
    logic [WIDTH-1:0]         sel_wdata;

    assign reqs      = {bus.r1_req, bus.r0_req};
    assign lock_full = (lock_cnt >= CW'(LOCK_MAX));

    rr_pick2 u_pick (
        .reqs       (reqs),
        .last       (last),
        .lock_valid (lock_valid),
        .lock_full  (lock_full),
        .grant      (grant)
    );

    assign other_req = grant ? bus.r0_req   : bus.r1_req;
    assign sel_wen   = grant ? bus.r1_wen   : bus.r0_wen;
    assign sel_lock  = grant ? bus.r1_lock  : bus.r0_lock;
    assign sel_addr  = grant ? bus.r1_addr  : bus.r0_addr;
    assign sel_wdata = grant ? bus.r1_wdata : bus.r0_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            cs_q       <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_q    <= PORT_CPU;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            last       <= PORT_DBG;
            lock_valid <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|reqs) begin
                        state      <= ISSUE;
                        busy_q     <= 1'b1;
                        cs_q       <= 1'b1;
                        owner_q    <= grant;
                        wen_q      <= sel_wen;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        lock_valid <= sel_lock;
                        // Only a locked re-grant against a waiting rival counts toward the bound.
                        if (grant == last && lock_valid && other_req) begin
                            if (!lock_full)
                                lock_cnt <= lock_cnt + CW'(1);
                        end else begin
                            lock_cnt <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state  <= RESP;
                    cs_q   <= 1'b0;
                    ack0_q <= (owner_q == PORT_CPU);
                    ack1_q <= (owner_q == PORT_DBG);
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    last   <= owner_q;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    cs_q   <= 1'b0;
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_cs    = cs_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
    assign bus.r0_ack    = ack0_q;
    assign bus.r1_ack    = ack1_q;

    // Memory data arrives one cycle after mem_cs, i.e. exactly in RESP; gate it by registered selects.
    assign bus.r0_rdata  = (ack0_q && !wen_q) ? bus.mem_rdata : '0;
    assign bus.r1_rdata  = (ack1_q && !wen_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arb;

    localparam int LOCK_MAX = 8;

    typedef struct {
        logic        port;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    mem_arb_if #(.WIDTH(32), .MEM_ADDR_SIZE(12)) bus ();

    mem_arb #(.WIDTH(32), .MEM_ADDR_SIZE(12), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [0:4095];

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 ^ 32'(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
            else             bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic p, input logic req, input logic wen, input logic lock,
                           input logic [11:0] addr, input logic [31:0] wdata);
        if (!p) begin
            bus.r0_req = req; bus.r0_wen = wen; bus.r0_lock = lock;
            bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_req = req; bus.r1_wen = wen; bus.r1_lock = lock;
            bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        tick;
        tick;
        chk1 ("rst_cs",     bus.mem_cs,   1'b0);
        chk1 ("rst_busy",   bus.busy,     1'b0);
        chk1 ("rst_owner",  bus.owner,    1'b0);
        chk1 ("rst_ack0",   bus.r0_ack,   1'b0);
        chk1 ("rst_ack1",   bus.r1_ack,   1'b0);
        chk1 ("rst_wen",    bus.mem_wen,  1'b0);
        chk32("rst_addr",   {20'h0, bus.mem_addr}, 32'h0);
        chk32("rst_wdata",  bus.mem_wdata, 32'h0);
        chk32("rst_rdata0", bus.r0_rdata, 32'h0);
        chk32("rst_rdata1", bus.r1_rdata, 32'h0);
        reset = 1'b1;
    endtask

    task automatic drain;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        repeat (5) tick;
        chk1("drain_idle", bus.busy, 1'b0);
    endtask

    // Single transaction from an idle arbiter; checks N+1, N+2 and N+3 cycles.
    task automatic do_txn(input vec_t v);
        set_req(v.port, 1'b1, v.wen, 1'b0, v.addr, v.wdata);
        tick;
        chk1 ("txn_cs",    bus.mem_cs,  1'b1);
        chk32("txn_addr",  {20'h0, bus.mem_addr}, {20'h0, v.addr});
        chk1 ("txn_wen",   bus.mem_wen, v.wen);
        chk1 ("txn_owner", bus.owner,   v.port);
        chk1 ("txn_busy",  bus.busy,    1'b1);
        if (v.wen) chk32("txn_wdata", bus.mem_wdata, v.wdata);
        tick;
        chk1 ("txn_cs_off",    bus.mem_cs, 1'b0);
        chk1 ("txn_ack_own",   v.port ? bus.r1_ack : bus.r0_ack, 1'b1);
        chk1 ("txn_ack_other", v.port ? bus.r0_ack : bus.r1_ack, 1'b0);
        chk32("txn_rdata_own",   v.port ? bus.r1_rdata : bus.r0_rdata, v.exp_rdata);
        chk32("txn_rdata_other", v.port ? bus.r0_rdata : bus.r1_rdata, 32'h0);
        set_req(v.port, 1'b0, v.wen, 1'b0, v.addr, v.wdata);
        tick;
        chk1("txn_busy_off", bus.busy, 1'b0);
        chk1("txn_ack_off",  v.port ? bus.r1_ack : bus.r0_ack, 1'b0);
    endtask

    task automatic lock_run(input int n_alone);
        int  cs_seen;
        int  n1;
        bit  got0;
        bit  raised;
        cs_seen = 0; n1 = 0; got0 = 0; raised = 0;
        set_req(1'b1, 1'b1, 1'b1, 1'b1, 12'h200, 32'h00001111);
        for (int c = 0; c < 150 && !got0; c++) begin
            tick;
            chk1("lock_both_ack", bus.r0_ack & bus.r1_ack, 1'b0);
            if (raised && bus.r1_ack) n1++;
            if (bus.r0_ack) got0 = 1;
            if (!raised && bus.mem_cs && bus.owner) begin
                cs_seen++;
                if (cs_seen == n_alone) begin
                    set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
                    raised = 1;
                end
            end
        end
        chk1 ("lock_port0_served", got0, 1'b1);
        chk32("lock_port1_grants", n1, 32'd9);
        drain;
    endtask

    // Reference model state for the randomized run (edges counted from reset release).
    int          e, free_e, g_edge;
    logic        g_port, g_wen;
    logic [11:0] g_addr;
    logic [31:0] g_wdata, g_rdata;
    logic        m_last, m_lockv;
    int          m_cnt;
    logic        pend [2];
    logic        p_wen [2];
    logic        p_lock [2];
    logic [11:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] ref_mem [16];

    task automatic decide(input int t);
        logic g;
        logic other;
        if (t >= free_e && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) g = (m_lockv && m_cnt < LOCK_MAX) ? m_last : ~m_last;
            else                    g = pend[1];
            other = pend[!g];
            if (g != m_last || !other) m_cnt = 0;
            else if (m_cnt < LOCK_MAX) m_cnt++;
            m_lockv = p_lock[g];
            m_last  = g;
            g_edge  = t;
            free_e  = t + 3;
            g_port  = g;
            g_wen   = p_wen[g];
            g_addr  = p_addr[g];
            g_wdata = p_wdata[g];
            if (g_wen) begin
                ref_mem[g_addr[3:0]] = g_wdata;
                g_rdata = 32'h0;
            end else begin
                g_rdata = ref_mem[g_addr[3:0]];
            end
        end
    endtask

    task automatic rnd_step(input bit allow_new);
        for (int p = 0; p < 2; p++) begin
            if (e == g_edge + 1 && g_port == p[0]) pend[p] = 1'b0;
            if (!pend[p] && allow_new && $urandom_range(0, 2) == 0) begin
                pend[p]    = 1'b1;
                p_wen[p]   = 1'($urandom_range(0, 1));
                p_lock[p]  = 1'($urandom_range(0, 1));
                p_addr[p]  = 12'h100 | 12'($urandom_range(0, 15));
                p_wdata[p] = $urandom;
            end
            set_req(p[0], pend[p], p_wen[p], p_lock[p], p_addr[p], p_wdata[p]);
        end
        decide(e + 1);
    endtask

    task automatic rnd_check;
        logic exp_cs, exp_a0, exp_a1, exp_busy;
        exp_cs   = (e == g_edge);
        exp_a0   = (e == g_edge + 1) && (g_port == 1'b0);
        exp_a1   = (e == g_edge + 1) && (g_port == 1'b1);
        exp_busy = (e == g_edge) || (e == g_edge + 1);
        chk1 ("rnd_cs",     bus.mem_cs, exp_cs);
        chk1 ("rnd_ack0",   bus.r0_ack, exp_a0);
        chk1 ("rnd_ack1",   bus.r1_ack, exp_a1);
        chk1 ("rnd_busy",   bus.busy,   exp_busy);
        chk32("rnd_rdata0", bus.r0_rdata, exp_a0 ? g_rdata : 32'h0);
        chk32("rnd_rdata1", bus.r1_rdata, exp_a1 ? g_rdata : 32'h0);
        if (g_edge >= 0 && e >= g_edge) chk1("rnd_owner", bus.owner, g_port);
        if (exp_cs) begin
            chk32("rnd_addr", {20'h0, bus.mem_addr}, {20'h0, g_addr});
            chk1 ("rnd_wen",  bus.mem_wen, g_wen);
            if (g_wen) chk32("rnd_wdata", bus.mem_wdata, g_wdata);
        end
    endtask

    vec_t vecs [8];
    int   ack_port [4];
    int   ack_t [4];
    int   na;
    int   cyc;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
        mem[12'h010] = 32'hDEADBEEF;
        mem[12'h030] = 32'h00003030;

        vecs[0] = '{1'b1, 1'b1, 12'hFFF, 32'h12345678, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 12'hFFF, 32'h0,        32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 12'h020, 32'h0000A5A5, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 12'h020, 32'h0,        32'h0000A5A5};
        vecs[5] = '{1'b0, 1'b1, 12'h000, 32'hCAFEF00D, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 12'h000, 32'h0,        32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b0, 12'h030, 32'h0,        32'h00003030};

        do_reset;
        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Field change after grant must not reach the memory bus.
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        tick;
        chk32("fld_addr_issue", {20'h0, bus.mem_addr}, 32'h020);
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h030, 32'h0);
        tick;
        chk32("fld_addr_resp", {20'h0, bus.mem_addr}, 32'h020);
        chk1 ("fld_ack",       bus.r0_ack, 1'b1);
        chk32("fld_rdata",     bus.r0_rdata, 32'h0000A5A5);
        drain;

        // Reset during ISSUE aborts; afterwards a tie goes to port 0.
        do_txn(vecs[2]);
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
        tick;
        chk1("mid_cs", bus.mem_cs, 1'b1);
        reset = 1'b0;
        tick;
        chk1 ("mid_cs_off", bus.mem_cs, 1'b0);
        chk1 ("mid_ack0",   bus.r0_ack, 1'b0);
        chk1 ("mid_ack1",   bus.r1_ack, 1'b0);
        chk1 ("mid_busy",   bus.busy,   1'b0);
        chk32("mid_addr",   {20'h0, bus.mem_addr}, 32'h0);
        tick;
        chk1 ("mid_ack0_b", bus.r0_ack, 1'b0);
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        reset = 1'b1;
        tick;
        chk1 ("mid_tie_cs",    bus.mem_cs, 1'b1);
        chk1 ("mid_tie_owner", bus.owner,  1'b0);
        tick;
        chk1 ("mid_tie_ack0",  bus.r0_ack, 1'b1);
        chk1 ("mid_tie_ack1",  bus.r1_ack, 1'b0);
        chk32("mid_tie_rdata", bus.r0_rdata, 32'hDEADBEEF);
        drain;

        // Both held out of reset: strict alternation, 3 cycles apart.
        do_reset;
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        na = 0; cyc = 0;
        while (na < 4 && cyc < 30) begin
            tick;
            cyc++;
            chk1("tie_both_ack", bus.r0_ack & bus.r1_ack, 1'b0);
            if (bus.r0_ack || bus.r1_ack) begin
                ack_port[na] = bus.r1_ack ? 1 : 0;
                ack_t[na]    = cyc;
                na++;
            end
        end
        chk32("tie_count", na, 32'd4);
        if (na > 0) chk32("tie_first_lat", ack_t[0], 32'd2);
        for (int i = 0; i < na; i++) chk32("tie_order", ack_port[i], i % 2);
        for (int i = 1; i < na; i++) chk32("tie_spacing", ack_t[i] - ack_t[i-1], 32'd3);
        drain;

        lock_run(1);
        lock_run(12);

        // Randomized run against the reference model.
        do_reset;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(12'h100 + i);
        e = 0; free_e = 1; g_edge = -10; g_port = 1'b0; g_wen = 1'b0;
        g_addr = 12'h0; g_wdata = 32'h0; g_rdata = 32'h0;
        m_last = 1'b1; m_lockv = 1'b0; m_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; p_wen[p] = 1'b0; p_lock[p] = 1'b0;
            p_addr[p] = 12'h100; p_wdata[p] = 32'h0;
        end
        rnd_step(1'b1);
        for (int i = 0; i < 3000; i++) begin
            tick;
            e++;
            rnd_check;
            rnd_step(i < 2970);
        end
        chk1("rnd_end_idle", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
